freq_window_counter: RTL and testbench
======================================

Name: freq_window_counter

Overview:
- Downstream consumer of the leading-edge detector: counts single-cycle edge pulses over a fixed gate window of clock cycles.
- Converts the window count to two decimal digits (tens, units) by iterative subtraction, and publishes them with a one-cycle valid strobe.
- Feeds the seven-segment display driver stage.

Parameters:
GATE_CYCLES, 1200, window length in clk cycles (>=2); edges counted in exactly this many cycles per window
CNT_W, 16, edge counter width; must satisfy 2^CNT_W-1 >= GATE_CYCLES

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
edge_pulse  input  1  one-cycle leading-edge strobe from edge_detect
digit_tens  output  4  tens digit of last completed window, 0..9
digit_units  output  4  units digit of last completed window, 0..9
data_valid  output  1  one-cycle strobe; digits updated this cycle
busy  output  1  high during conversion (TENS/UNITS); edges ignored

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). Polarity and synchronicity are fixed.
- Reset: state=COUNT, window_ctr=0, edge_ctr=0, digit_tens=0, digit_units=0, data_valid=0, busy=0. Reset asserted in any state aborts the window or conversion. Digits return to 0.
- The first window starts in the first cycle after reset deasserts.
- States: COUNT, TENS, UNITS. All outputs are registered.
- COUNT state:
  - window_ctr increments every cycle.
  - If edge_pulse=1, edge_ctr increments, saturating at 2^CNT_W-1.
  - When window_ctr==GATE_CYCLES-1, that cycle's pulse is still counted. Next cycle: state=TENS, value=min(edge_ctr incl. this cycle's pulse, 99), tens=0.
- TENS state:
  - If value>=10: value-=10, tens+=1, stay in TENS.
  - Else: go to UNITS.
  - Takes tens+1 cycles.
- UNITS state (1 cycle): digit_tens<=tens, digit_units<=value, data_valid<=1. Next state=COUNT with window_ctr=0 and edge_ctr=0.
- data_valid is high exactly in the first cycle of the new window, then 0.
- Dead time: edge_pulse is ignored in TENS and UNITS; it is not counted in any window.
  - Dead time = tens+2 cycles.
  - Window period = GATE_CYCLES+tens+2 cycles.
- busy=1 exactly while state is TENS or UNITS.
- Saturation: any count >=99 (including counter saturation) publishes 9,9.
- Zero edges publishes 0,0, with data_valid still pulsed.
- Back-to-back edge pulses in consecutive cycles are all counted; there is no minimum spacing.
- Digits hold their last published value between strobes.

Optional Feature:
- Macro: FREQ_WINDOW_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit), reset 0.
  - overflow is updated with the digits in UNITS: 1 if the raw window count was >99, else 0.
  - overflow holds until the next strobe.
  - Display shows 9,9 either way.
- Undefined: the port does not exist. Saturation behaviour is unchanged.

Test Plan:
- GATE_CYCLES=100. Reset 3 cycles, then 37 pulses in window 1 -> busy high for 5 cycles; data_valid exactly 6 cycles after the window's last cycle; digits 3,7.
- 0 pulses in a window -> digits 0,0; data_valid pulses; busy high 2 cycles; next window starts immediately.
- 100 pulses (every cycle) in a window -> digits 9,9. With macro: overflow=1; then 50 pulses in the next window -> digits 5,0, overflow=0.
- Pulse on window cycle 99 and on the first TENS cycle -> the first is counted, the second is not (window total off by exactly the pulses in dead time).
- Reset asserted mid-TENS after a 64-pulse window -> digits 0,0, data_valid never pulses for that window; fresh window of GATE_CYCLES follows.
- Pulse on window cycle 0 of the window after a publish -> counted in the new window; data_valid and counting coexist in the same cycle.

Source files
------------

// File: rtl/freq_window_counter.sv
// Counts edge pulses per GATE_CYCLES window, publishes two BCD digits with a valid strobe; FREQ_WINDOW_OVERFLOW_EN adds an overflow flag.
// Latency: digits appear tens+3 cycles after the window's last cycle; no backpressure, edges are dropped while busy.
module freq_window_counter #(
  parameter int GATE_CYCLES = 1200,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       edge_pulse,
  output logic [3:0] digit_tens,
  output logic [3:0] digit_units,
  output logic       data_valid,
  output logic       busy
`ifdef FREQ_WINDOW_OVERFLOW_EN
  ,
  output logic       overflow
`endif
);

  localparam int WIN_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] S_COUNT = 2'd0;
  localparam logic [1:0] S_TENS  = 2'd1;
  localparam logic [1:0] S_UNITS = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] edge_q, edge_d;
  logic [6:0]       val_q, val_d;
  logic [3:0]       tens_q, tens_d;
  logic [3:0]       dig_tens_q, dig_tens_d;
  logic [3:0]       dig_units_q, dig_units_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             ovf_pend_q, ovf_pend_d;

  logic [CNT_W-1:0] edge_nxt;
  logic [31:0]      edge_ext;
  logic [6:0]       val_win;

  // This cycle's pulse is included, so the final window cycle is counted too.
  assign edge_nxt = (edge_pulse && (edge_q != CNT_MAX)) ? edge_q + CNT_W'(1) : edge_q;
  assign edge_ext = 32'(edge_nxt);
  assign val_win  = (edge_ext > 32'd99) ? 7'd99 : edge_ext[6:0];

`ifdef FREQ_WINDOW_OVERFLOW_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    edge_d      = edge_q;
    val_d       = val_q;
    tens_d      = tens_q;
    dig_tens_d  = dig_tens_q;
    dig_units_d = dig_units_q;
    vld_d       = 1'b0;
    busy_d      = busy_q;
    ovf_pend_d  = ovf_pend_q;
`ifdef FREQ_WINDOW_OVERFLOW_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      S_COUNT: begin
        win_d  = win_q + WIN_W'(1);
        edge_d = edge_nxt;
        if (win_q == WIN_LAST) begin
          state_d    = S_TENS;
          busy_d     = 1'b1;
          win_d      = '0;
          val_d      = val_win;
          tens_d     = 4'd0;
          ovf_pend_d = (edge_ext > 32'd99);
        end
      end
      S_TENS: begin
        if (val_q >= 7'd10) begin
          val_d  = val_q - 7'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          state_d = S_UNITS;
        end
      end
      S_UNITS: begin
        dig_tens_d  = tens_q;
        dig_units_d = val_q[3:0];
        vld_d       = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_COUNT;
        win_d       = '0;
        edge_d      = '0;
`ifdef FREQ_WINDOW_OVERFLOW_EN
        ovf_d       = ovf_pend_q;
`endif
      end
      default: begin
        state_d = S_COUNT;
        busy_d  = 1'b0;
        win_d   = '0;
        edge_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_COUNT;
      win_q       <= '0;
      edge_q      <= '0;
      val_q       <= '0;
      tens_q      <= '0;
      dig_tens_q  <= '0;
      dig_units_q <= '0;
      vld_q       <= 1'b0;
      busy_q      <= 1'b0;
      ovf_pend_q  <= 1'b0;
`ifdef FREQ_WINDOW_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      edge_q      <= edge_d;
      val_q       <= val_d;
      tens_q      <= tens_d;
      dig_tens_q  <= dig_tens_d;
      dig_units_q <= dig_units_d;
      vld_q       <= vld_d;
      busy_q      <= busy_d;
      ovf_pend_q  <= ovf_pend_d;
`ifdef FREQ_WINDOW_OVERFLOW_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign digit_tens  = dig_tens_q;
  assign digit_units = dig_units_q;
  assign data_valid  = vld_q;
  assign busy        = busy_q;
`ifdef FREQ_WINDOW_OVERFLOW_EN
  assign overflow    = ovf_q;
`endif

endmodule

// File: tb/tb_freq_window_counter.sv
// Bench for freq_window_counter with a 100-cycle gate; expected digits are queued per window and checked on data_valid.
module tb_freq_window_counter;
  localparam int GATE = 100;

  logic       clk;
  logic       reset;
  logic       edge_pulse;
  logic [3:0] digit_tens;
  logic [3:0] digit_units;
  logic       data_valid;
  logic       busy;
`ifdef FREQ_WINDOW_OVERFLOW_EN
  logic       overflow;
`endif

  freq_window_counter #(.GATE_CYCLES(GATE), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .edge_pulse  (edge_pulse),
    .digit_tens  (digit_tens),
    .digit_units (digit_units),
    .data_valid  (data_valid),
    .busy        (busy)
`ifdef FREQ_WINDOW_OVERFLOW_EN
    ,
    .overflow    (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int sb_q[$];       // bits 7:0 = {tens,units}, bit 8 = overflow
  int prev_dig = 0;  // digits currently expected on the outputs
  bit pend_vld = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every strobe must match the oldest outstanding window.
  always @(negedge clk) begin
    if (data_valid) begin
      if (sb_q.size() == 0) begin
        chk("spurious_vld", 1, 0);
      end else begin
        int e;
        e = sb_q.pop_front();
        chk("digits", int'({digit_tens, digit_units}), e & 255);
`ifdef FREQ_WINDOW_OVERFLOW_EN
        chk("overflow", int'(overflow), (e >> 8) & 1);
`endif
      end
    end
  end

  task automatic run_window(input logic [GATE-1:0] pat, output int cnt);
    cnt = 0;
    for (int i = 0; i < GATE; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("vld_first", int'(data_valid), int'(pend_vld));
        chk("busy_win0", int'(busy), 0);
      end else if (i == 1) begin
        chk("vld_one_cycle", int'(data_valid), 0);
      end
      reset      = 1'b0;
      edge_pulse = pat[i];
      cnt += int'(pat[i]);
    end
  endtask

  task automatic dead_time(input int cnt, input bit dead_pulse);
    int v, t, u, dig;
    v   = (cnt > 99) ? 99 : cnt;
    t   = v / 10;
    u   = v % 10;
    dig = t * 16 + u;
    sb_q.push_back(dig | ((cnt > 99) ? 256 : 0));
    for (int d = 0; d < t + 2; d++) begin
      @(negedge clk);
      chk("busy_dead", int'(busy), 1);
      chk("vld_dead", int'(data_valid), 0);
      chk("hold", int'({digit_tens, digit_units}), prev_dig);
      edge_pulse = dead_pulse;
    end
    prev_dig = dig;
    pend_vld = 1'b1;
  endtask

  initial begin
    logic [GATE-1:0] pat;
    int cnt;

    reset      = 1'b1;
    edge_pulse = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_digits", int'({digit_tens, digit_units}), 0);
      chk("rst_vld", int'(data_valid), 0);
      chk("rst_busy", int'(busy), 0);
    end

    // 37 spread pulses -> 3,7 with 5 busy cycles
    pat = '0;
    for (int i = 0; i < 37; i++) pat[2*i+1] = 1'b1;
    run_window(pat, cnt);
    chk("cnt37", cnt, 37);
    dead_time(cnt, 1'b0);

    // empty window -> 0,0 with 2 busy cycles
    pat = '0;
    run_window(pat, cnt);
    dead_time(cnt, 1'b0);

    // pulse every cycle -> 9,9 (overflow)
    pat = '1;
    run_window(pat, cnt);
    dead_time(cnt, 1'b0);

    // 50 pulses starting on cycle 0, coinciding with the previous strobe
    pat = '0;
    for (int i = 0; i < 50; i++) pat[i] = 1'b1;
    run_window(pat, cnt);
    dead_time(cnt, 1'b0);

    // last window cycle counted, pulses throughout dead time ignored -> 1,2
    pat = '0;
    pat[GATE-1] = 1'b1;
    for (int i = 10; i < 21; i++) pat[i] = 1'b1;
    run_window(pat, cnt);
    dead_time(cnt, 1'b1);

    // 64 pulses, then reset in the middle of TENS: no strobe for this window
    pat = '0;
    for (int i = 0; i < 64; i++) pat[i] = 1'b1;
    run_window(pat, cnt);
    @(negedge clk);
    chk("busy_tens1", int'(busy), 1);
    edge_pulse = 1'b0;
    @(negedge clk);
    chk("busy_tens2", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_digits", int'({digit_tens, digit_units}), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_vld", int'(data_valid), 0);
    prev_dig = 0;
    pend_vld = 1'b0;

    // fresh window after reset: first and last cycles both counted -> 0,9
    pat = '0;
    pat[0] = 1'b1;
    pat[GATE-1] = 1'b1;
    for (int i = 40; i < 47; i++) pat[i] = 1'b1;
    run_window(pat, cnt);
    dead_time(cnt, 1'b1);

    // random densities
    for (int k = 0; k < 3; k++) begin
      int thr;
      thr = $urandom_range(10, 90);
      for (int i = 0; i < GATE; i++) pat[i] = ($urandom_range(0, 99) < thr);
      run_window(pat, cnt);
      dead_time(cnt, $urandom_range(0, 1) == 1);
    end

    @(negedge clk);
    chk("vld_last", int'(data_valid), 1);
    edge_pulse = 1'b0;
    @(negedge clk);
    chk("vld_last_clear", int'(data_valid), 0);
    chk("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
